// File: rtl/prbs31_pkg.sv
// Shared PRBS31 definitions (x^31 + x^28 + 1) used by the checker and the upstream generator.
package prbs31_pkg;
    localparam int PRBS_W = 31;
    localparam int TAP_A  = 27;
    localparam int TAP_B  = 30;

    typedef logic [1:0] state_t;
    localparam state_t ST_SEED   = 2'd0;
    localparam state_t ST_VERIFY = 2'd1;
    localparam state_t ST_LOCKED = 2'd2;

    // r[0] is the newest bit, so r[30] is b[n-31] and r[27] is b[n-28].
    function automatic logic prbs31_predict(input logic [PRBS_W-1:0] r);
        return r[TAP_A] ^ r[TAP_B];
    endfunction
endpackage

// File: rtl/prbs31_err_window.sv
// Loss-of-lock detector: counts errors over a sliding-by-wrap window of locked valid bits.
module prbs31_err_window #(
    parameter int LOL_WINDOW = 256,
    parameter int LOL_ERRS   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic step,
    input  logic err,
    output logic lol
);
    localparam int BW = $clog2(LOL_WINDOW + 1);
    localparam int EW = $clog2(LOL_ERRS + 1);

    logic [BW-1:0] win_bits;
    logic [EW-1:0] win_errs;
    logic          wrap;

    assign wrap = (win_bits == BW'(LOL_WINDOW - 1));
    // Fires on the edge that samples the LOL_ERRS-th error of the window.
    assign lol  = active && step && err && (win_errs == EW'(LOL_ERRS - 1));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            win_bits <= '0;
            win_errs <= '0;
        end else if (active && step) begin
            if (lol || wrap) begin
                win_bits <= '0;
                win_errs <= '0;
            end else begin
                win_bits <= win_bits + 1'b1;
                if (err) win_errs <= win_errs + 1'b1;
            end
        end
    end
endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 serial checker: seeds from the stream, verifies, then self-runs and counts bit errors.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int VERIFY_LEN = 64,
    parameter int LOL_WINDOW = 256,
    parameter int LOL_ERRS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);
    localparam int PMAX = (VERIFY_LEN > PRBS_W) ? VERIFY_LEN : PRBS_W;
    localparam int PW   = $clog2(PMAX + 1);

    state_t            state;
    logic [PRBS_W-1:0] r;
    logic [PRBS_W-1:0] r_in;
    logic [PW-1:0]     phase;
    logic              pred;
    logic              mism;
    logic              lol;
    logic              bit_evt;
    logic              err_evt;

    assign pred    = prbs31_predict(r);
    assign mism    = bit_in ^ pred;
    assign r_in    = {r[PRBS_W-2:0], bit_in};
    assign bit_evt = bit_valid && (state == ST_LOCKED);
    assign err_evt = bit_evt && mism;

    prbs31_err_window #(
        .LOL_WINDOW (LOL_WINDOW),
        .LOL_ERRS   (LOL_ERRS)
    ) u_win (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (state == ST_LOCKED),
        .step   (bit_valid),
        .err    (mism),
        .lol    (lol)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= ST_SEED;
            r      <= '0;
            phase  <= '0;
            locked <= 1'b0;
        end else if (bit_valid) begin
            case (state)
                ST_SEED: begin
                    r <= r_in;
                    if (phase == PW'(PRBS_W - 1)) begin
                        phase <= '0;
                        // An all-zero history would predict zeros forever; reseed instead.
                        if (r_in != '0) state <= ST_VERIFY;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    r <= r_in;
                    if (mism) begin
                        state <= ST_SEED;
                        phase <= '0;
                    end else if (phase == PW'(VERIFY_LEN - 1)) begin
                        state  <= ST_LOCKED;
                        locked <= 1'b1;
                        phase  <= '0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so a flipped input bit costs one error only.
                    r <= {r[PRBS_W-2:0], pred};
                    if (lol) begin
                        state  <= ST_SEED;
                        locked <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_SEED;
                    locked <= 1'b0;
                    phase  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            err_pulse <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            err_pulse <= err_evt;
            if (clear_cnt)                        err_count <= {15'd0, err_evt};
            else if (err_evt && err_count != '1)  err_count <= err_count + 1'b1;
            if (clear_cnt)                        bit_count <= {31'd0, bit_evt};
            else if (bit_evt && bit_count != '1)  bit_count <= bit_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_prbs31_checker.sv
// Directed bench for prbs31_checker driven by an independent PRBS31 generator model.
module tb_prbs31_checker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        bit_in;
    logic        bit_valid;
    logic        clear_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] bit_count;

    logic [30:0] g;
    int          errors = 0;
    int          checks = 0;
    logic        seen;

    always #5 clk = ~clk;

    prbs31_checker #(
        .VERIFY_LEN (64),
        .LOL_WINDOW (256),
        .LOL_ERRS   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clear_cnt (clear_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one generator bit (optionally inverted); the generator only advances on valid bits.
    task automatic send(input logic inv, input logic vld, input logic clr);
        logic b;
        b         = g[27] ^ g[30];
        bit_in    = b ^ inv;
        bit_valid = vld;
        clear_cnt = clr;
        @(posedge clk);
        #1;
        if (vld) g = {g[29:0], b};
        bit_valid = 1'b0;
        clear_cnt = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b1, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear_cnt = 1'b0;
        g = 31'h2AAA_5555;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_bit_count", bit_count, 0);
        rst_n = 1'b0;

        // Acquisition: 31 seed + 64 verify bits
        run(94);
        chk("lock_after_94", locked, 0);
        run(1);
        chk("lock_after_95", locked, 1);
        run(10000 - 95);
        chk("clean_err_count", err_count, 0);
        chk("clean_bit_count", bit_count, 9905);
        chk("clean_locked", locked, 1);

        // Single inverted bit while locked
        run(999);
        send(1'b1, 1'b1, 1'b0);
        chk("single_err_pulse", err_pulse, 1);
        chk("single_err_count", err_count, 1);
        send(1'b0, 1'b1, 1'b0);
        chk("single_pulse_width", err_pulse, 0);
        run(300);
        chk("single_err_hold", err_count, 1);
        chk("single_locked", locked, 1);

        // clear_cnt coinciding with counted events
        send(1'b1, 1'b1, 1'b1);
        chk("clr_err_evt", err_count, 1);
        chk("clr_bit_evt", bit_count, 1);
        send(1'b0, 1'b1, 1'b1);
        chk("clr_no_err", err_count, 0);
        chk("clr_bit_evt2", bit_count, 1);

        // Asynchronous reset mid-lock, with err_pulse high
        send(1'b1, 1'b1, 1'b0);
        chk("pre_rst_pulse", err_pulse, 1);
        rst_n = 1'b1;
        #1;
        chk("async_locked", locked, 0);
        chk("async_err_pulse", err_pulse, 0);
        chk("async_err_count", err_count, 0);
        chk("async_bit_count", bit_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // Relock with bit_valid toggling; invalid cycles present the wrong bit
        for (int i = 0; i < 94; i++) begin
            send(1'b0, 1'b1, 1'b0);
            send(1'b1, 1'b0, 1'b0);
        end
        chk("toggle_lock_94", locked, 0);
        send(1'b0, 1'b1, 1'b0);
        chk("toggle_lock_95", locked, 1);

        // Loss of lock: 8 errors in the first window after lock
        for (int k = 1; k <= 8; k++) begin
            run(9);
            send(1'b1, 1'b1, 1'b0);
            if (k == 7) chk("lol_after_7", locked, 1);
        end
        chk("lol_after_8", locked, 0);
        chk("lol_err_count", err_count, 8);
        chk("lol_bit_count", bit_count, 80);
        run(94);
        chk("relock_94", locked, 0);
        run(1);
        chk("relock_95", locked, 1);
        chk("relock_err_count", err_count, 8);
        chk("relock_bit_count", bit_count, 80);

        // Constant-zero input never locks
        pulse_reset();
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            bit_in = 1'b0;
            bit_valid = 1'b1;
            @(posedge clk);
            #1;
            if (locked) seen = 1'b1;
        end
        bit_valid = 1'b0;
        chk("zeros_never_locked", seen, 0);
        chk("zeros_bit_count", bit_count, 0);

        // err_count saturation
        pulse_reset();
        run(95);
        chk("sat_locked", locked, 1);
        force dut.err_count = 16'hFFFF;
        #1;
        release dut.err_count;
        send(1'b1, 1'b1, 1'b0);
        chk("sat_err_count", err_count, 16'hFFFF);
        chk("sat_err_pulse", err_pulse, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prbs31_checker.md
PRBS31_CHECKER -- requirements
Module: prbs31_checker

Interface
REQ-001 SHALL have parameter VERIFY_LEN, default 64, meaning the number of consecutive error-free bits required after seeding before lock is declared.
REQ-002 SHALL have parameter LOL_WINDOW, default 256, meaning the loss-of-lock observation window length in valid bits.
REQ-003 SHALL have parameter LOL_ERRS, default 8, meaning the error count within one window that forces loss of lock.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port bit_in, input, 1 bit: serial PRBS31 bit from the upstream generator.
REQ-007 SHALL have port bit_valid, input, 1 bit: bit_in is sampled only when this is high.
REQ-008 SHALL have port clear_cnt, input, 1 bit: synchronous clear of err_count and bit_count.
REQ-009 SHALL have port locked, output, 1 bit: checker is synchronised.
REQ-010 SHALL have port err_pulse, output, 1 bit: one-cycle flag for each mismatched bit while locked.
REQ-011 SHALL have port err_count, output, 16 bits: saturating count of mismatched bits.
REQ-012 SHALL have port bit_count, output, 32 bits: saturating count of bits checked while locked.

Function
REQ-013 SHALL hold a 31-bit history register r, with r[0] the newest bit, and predict each bit as r[27] XOR r[30] (polynomial x^31+x^28+1).
REQ-014 SHALL implement states SEED, VERIFY and LOCKED; a cycle with bit_valid low SHALL change no state, counter or register.
REQ-015 In SEED, the block SHALL shift each valid bit_in into r and, after 31 valid bits, enter VERIFY.
REQ-016 On entering VERIFY, if r is all zeros, the block SHALL return to SEED and restart seeding.
REQ-017 In VERIFY, the block SHALL shift bit_in into r, return to SEED on any mismatch, and enter LOCKED after VERIFY_LEN consecutive matches.
REQ-018 In LOCKED, the block SHALL shift the predicted bit (not bit_in) into r, so a single flipped input bit yields exactly one error.
REQ-019 In LOCKED, a mismatch SHALL assert err_pulse for exactly the cycle after the sampling edge and SHALL increment err_count, saturating at 0xFFFF.
REQ-020 In LOCKED, each valid bit SHALL increment bit_count, saturating at 0xFFFFFFFF; bits in SEED and VERIFY SHALL NOT be counted.
REQ-021 In LOCKED, the block SHALL count window errors over LOL_WINDOW valid bits and clear that count at each window wrap.
REQ-022 When the window error count reaches LOL_ERRS, the block SHALL go to SEED on the next edge and deassert locked; err_count and bit_count SHALL be retained.
REQ-023 locked SHALL be registered and high exactly while the state is LOCKED.
REQ-024 If clear_cnt and a counted event coincide, the counter SHALL load 1; clear_cnt SHALL NOT affect state, r or the window counters.

Reset
REQ-025 While rst_n is high, the block SHALL be in state SEED with r = 0, all internal counters = 0, locked = 0, err_pulse = 0, err_count = 0 and bit_count = 0.
REQ-026 Reset SHALL act immediately, including mid-lock, and operation SHALL resume from SEED on the first valid bit after release.

Structure
REQ-027 The PRBS31 tap positions (27, 30), the register width (31) and the state encoding typedef SHALL live in a shared package that is also used by the generator.
REQ-028 The block SHALL use one sub-module, prbs31_err_window, containing the window bit counter, the window error counter and the LOL_ERRS compare.

Verification
REQ-029 Bench SHALL cover: upstream generator reset-released, bit_valid=1 -> locked rises the cycle after the 95th bit, and err_count=0 after 10000 bits.
REQ-030 Bench SHALL cover: locked stream with bit 1000 inverted -> a single err_pulse, err_count=1, locked stays high.
REQ-031 Bench SHALL cover: constant-zero bit_in for 1000 bits -> locked never asserts.
REQ-032 Bench SHALL cover: 8 inversions within 256 bits while locked -> locked falls, relocks 95 clean bits later, err_count=8.
REQ-033 Bench SHALL cover: clear_cnt asserted in the same cycle as a counted error -> err_count=1; bit_valid toggled 50% -> lock timing is unchanged in valid-bit terms.
REQ-034 Bench SHALL cover: rst_n pulsed while locked -> all outputs 0 immediately; forced err_count 0xFFFF plus one error -> stays 0xFFFF.
